// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   REG_W / CNT_W      : register specifier and performance counter widths
//   FWD_*              : ALU operand mux select encodings
//   ctrl_state_e       : informational control state (RUN / STALL / FLUSH)
//   slot_t             : one scoreboard entry describing an in-flight instruction
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from the MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from the EX/MEM result

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] dest;
  } slot_t;

endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID-stage request fields and hazard-control responses.
//   master : the pipeline side; drives ID_* fields and EX_BranchTaken
//   slave  : the hazard controller; drives stall/flush controls, forward
//            selects and the two performance counters
interface hazard_controller_if;
  import hazard_pkg::*;

  logic             ID_Valid;
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_RegWrite;
  logic             ID_MemRead;
  logic [REG_W-1:0] ID_WriteReg;
  logic             EX_BranchTaken;

  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCycles;

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
           ID_RegWrite, ID_MemRead, ID_WriteReg, EX_BranchTaken,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
           ForwardA, ForwardB, StallCycles, FlushCycles
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt,
           ID_RegWrite, ID_MemRead, ID_WriteReg, EX_BranchTaken,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble,
           ForwardA, ForwardB, StallCycles, FlushCycles
  );

endinterface

// File: rtl/hazard_controller_src_match.sv
// src_match: combinational compare of one ID source register against one
// scoreboard slot.
//   src   : source register specifier from ID
//   uses  : the ID instruction really reads this source
//   slot  : scoreboard entry to compare against
//   match : the slot will write the register this source reads
module src_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             uses,
  input  slot_t            slot,
  output logic             match
);

  // $0 is hard-wired to zero, so a write to it never creates a dependency.
  assign match = uses && slot.valid && slot.regwrite &&
                 (slot.dest != '0) && (slot.dest == src);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: scoreboard-based hazard unit for the 5-stage pipeline.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : slave side of hazard_controller_if
//     inputs  ID_* fields of the instruction in ID, EX_BranchTaken
//     outputs PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble (combinational),
//             ForwardA/ForwardB (registered, used while that instruction is
//             in EX), StallCycles/FlushCycles (saturating counters)
module hazard_controller
  import hazard_pkg::*;
(
  input logic                Clk,
  input logic                Reset,
  hazard_controller_if.slave bus
);

  slot_t            ex_q, ex_d;
  slot_t            mem_q, mem_d;
  slot_t            wb_q, wb_d;
  ctrl_state_e      state_q, state_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_ex_match, rs_mem_match, rt_ex_match, rt_mem_match;
  logic load_use, flush, bubble;
  logic pc_write, ifid_write, ifid_flush, idex_bubble;

  src_match u_rs_ex  (.src(bus.ID_Rs), .uses(bus.ID_UsesRs), .slot(ex_q),  .match(rs_ex_match));
  src_match u_rs_mem (.src(bus.ID_Rs), .uses(bus.ID_UsesRs), .slot(mem_q), .match(rs_mem_match));
  src_match u_rt_ex  (.src(bus.ID_Rt), .uses(bus.ID_UsesRt), .slot(ex_q),  .match(rt_ex_match));
  src_match u_rt_mem (.src(bus.ID_Rt), .uses(bus.ID_UsesRt), .slot(mem_q), .match(rt_mem_match));

  // A load in EX cannot forward (its data is not ready), so it is skipped
  // here; if ID really needs it, load-use has already stalled this cycle.
  function automatic logic [1:0] fwd_select(logic ex_m, logic mem_m, logic ex_is_load);
    if (ex_m && !ex_is_load) return FWD_MEM;
    if (mem_m)               return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    load_use    = bus.ID_Valid && ex_q.memread && (rs_ex_match || rt_ex_match);
    flush       = bus.EX_BranchTaken;
    bubble      = flush || load_use;

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!Reset) begin
      if (flush) begin
        // The branch target must load, so the PC keeps running even if a
        // load-use condition is also present.
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    mem_d = ex_q;
    wb_d  = mem_q;
    ex_d  = '0;
    if (!bubble) begin
      ex_d.valid    = bus.ID_Valid;
      ex_d.regwrite = bus.ID_RegWrite;
      ex_d.memread  = bus.ID_MemRead;
      ex_d.dest     = bus.ID_WriteReg;
    end

    // Selects belong to the instruction entering EX; a bubble needs none.
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      fwd_a_d = fwd_select(rs_ex_match, rs_mem_match, ex_q.memread);
      fwd_b_d = fwd_select(rt_ex_match, rt_mem_match, ex_q.memread);
    end

    if (flush)         state_d = FLUSH;
    else if (load_use) state_d = STALL;
    else               state_d = RUN;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (state_d == STALL && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (state_d == FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // values, so ordering of these statements cannot change behaviour.
    if (Reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= RUN;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      state_q     <= state_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While in STALL the EX slot holds the bubble just inserted, so a second
  // back-to-back load-use stall is impossible.
  always_ff @(posedge Clk) begin
    if (!Reset) assert (!(state_q == STALL && load_use));
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IFID_Write  = ifid_write;
  assign bus.IFID_Flush  = ifid_flush;
  assign bus.IDEX_Bubble = idex_bubble;
  assign bus.ForwardA    = fwd_a_q;
  assign bus.ForwardB    = fwd_b_q;
  assign bus.StallCycles = stall_cnt_q;
  assign bus.FlushCycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed table of instruction sequences, a reset-in-
// stall sequence, then randomized traffic against an in-flight-history model.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_controller_if bus ();

  hazard_controller dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit        rst;
    bit        v;
    bit [4:0]  rs, rt;
    bit        us, ut, wr, ld;
    bit [4:0]  wd;
    bit        br;
    bit        pc, ifw, fl, bub;
    bit [1:0]  fa, fb;
    bit [31:0] sc, fc;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, bit v, int rs, int rt, bit us, bit ut, bit wr, bit ld,
                              int wd, bit br, bit pc, bit ifw, bit fl, bit bub,
                              int fa, int fb, int sc, int fc);
    vec_t r;
    r.rst = rst; r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.us = us; r.ut = ut;
    r.wr = wr; r.ld = ld; r.wd = 5'(wd); r.br = br;
    r.pc = pc; r.ifw = ifw; r.fl = fl; r.bub = bub;
    r.fa = 2'(fa); r.fb = 2'(fb); r.sc = 32'(sc); r.fc = 32'(fc);
    return r;
  endfunction

  // Drive one ID-stage cycle just after a rising edge, check on the falling
  // edge, then advance to just after the next rising edge.
  task automatic apply_row(input vec_t r, input string tag);
    reset              = r.rst;
    bus.ID_Valid       = r.v;
    bus.ID_Rs          = r.rs;
    bus.ID_Rt          = r.rt;
    bus.ID_UsesRs      = r.us;
    bus.ID_UsesRt      = r.ut;
    bus.ID_RegWrite    = r.wr;
    bus.ID_MemRead     = r.ld;
    bus.ID_WriteReg    = r.wd;
    bus.EX_BranchTaken = r.br;
    @(negedge clk);
    check({tag, ".PCWrite"},     32'(bus.PCWrite),     32'(r.pc));
    check({tag, ".IFID_Write"},  32'(bus.IFID_Write),  32'(r.ifw));
    check({tag, ".IFID_Flush"},  32'(bus.IFID_Flush),  32'(r.fl));
    check({tag, ".IDEX_Bubble"}, 32'(bus.IDEX_Bubble), 32'(r.bub));
    check({tag, ".ForwardA"},    32'(bus.ForwardA),    32'(r.fa));
    check({tag, ".ForwardB"},    32'(bus.ForwardB),    32'(r.fb));
    check({tag, ".StallCycles"}, bus.StallCycles,      r.sc);
    check({tag, ".FlushCycles"}, bus.FlushCycles,      r.fc);
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: the last three instructions that left ID ----------
  typedef struct packed {bit v; bit wr; bit ld; bit [4:0] d;} ent_t;
  ent_t      hist [3];          // [0] youngest (in EX), [1] MEM, [2] WB
  bit [1:0]  m_fa, m_fb;
  bit [31:0] m_sc, m_fc;

  function automatic bit writes(ent_t e, bit [4:0] r);
    return e.v && e.wr && (r != 0) && (e.d == r);
  endfunction

  // Forward from the nearest older producer still in flight: one ahead comes
  // from EX/MEM, two ahead from MEM/WB, further needs nothing.
  function automatic bit [1:0] fwd_for(bit uses, bit [4:0] r);
    if (!uses) return 2'b00;
    for (int d = 0; d < 2; d++)
      if (writes(hist[d], r)) return (d == 0) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  vec_t tbl [27];

  initial begin
    vec_t r;
    bit   held;
    bit   lu;

    // ---- directed table -------------------------------------------------
    //            rst v rs rt us ut wr ld wd br  pc ifw fl bub fa fb sc fc
    tbl[0]  = mk(0, 1, 1, 2, 1, 1, 1, 0, 3, 0,  1, 1, 0, 0,  0, 0, 0, 0); // add $3,$1,$2
    tbl[1]  = mk(0, 1, 3, 5, 1, 1, 1, 0, 4, 0,  1, 1, 0, 0,  0, 0, 0, 0); // sub $4,$3,$5
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  2, 0, 0, 0); // sub in EX: A=10
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0);
    tbl[4]  = mk(0, 1, 1, 2, 1, 1, 1, 0, 3, 0,  1, 1, 0, 0,  0, 0, 0, 0); // add $3
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0); // nop
    tbl[6]  = mk(0, 1, 3, 3, 1, 1, 1, 0, 6, 0,  1, 1, 0, 0,  0, 0, 0, 0); // or $6,$3,$3
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 0, 0); // or in EX: 01/01
    tbl[8]  = mk(0, 1, 1, 2, 1, 1, 1, 0, 3, 0,  1, 1, 0, 0,  0, 0, 0, 0); // add $3,$1,$2
    tbl[9]  = mk(0, 1, 4, 5, 1, 1, 1, 0, 3, 0,  1, 1, 0, 0,  0, 0, 0, 0); // add $3,$4,$5
    tbl[10] = mk(0, 1, 3, 1, 1, 1, 1, 0, 7, 0,  1, 1, 0, 0,  0, 0, 0, 0); // sub $7,$3,$1
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  2, 0, 0, 0); // EX/MEM wins
    tbl[12] = mk(0, 1, 1, 2, 1, 0, 1, 1, 2, 0,  1, 1, 0, 0,  0, 0, 0, 0); // lw $2,0($1)
    tbl[13] = mk(0, 1, 2, 2, 1, 1, 1, 0, 4, 0,  0, 0, 0, 1,  0, 0, 0, 0); // add $4,$2,$2 stalls
    tbl[14] = mk(0, 1, 2, 2, 1, 1, 1, 0, 4, 0,  1, 1, 0, 0,  0, 0, 1, 0); // add re-presented
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 1, 0); // add in EX: 01/01
    tbl[16] = mk(0, 1, 1, 0, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0,  0, 0, 1, 0); // lw $0,0($1)
    tbl[17] = mk(0, 1, 0, 0, 1, 1, 1, 0, 5, 0,  1, 1, 0, 0,  0, 0, 1, 0); // or $5,$0,$0 no stall
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 1, 0); // no forward of $0
    tbl[19] = mk(0, 1, 1, 2, 1, 0, 1, 1, 2, 0,  1, 1, 0, 0,  0, 0, 1, 0); // lw $2
    tbl[20] = mk(0, 1, 2, 2, 1, 1, 1, 0, 4, 1,  1, 1, 1, 1,  0, 0, 1, 0); // load-use + branch
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 1, 1);
    tbl[22] = mk(0, 1, 1, 2, 1, 0, 1, 1, 2, 0,  1, 1, 0, 0,  0, 0, 1, 1); // lw $2
    tbl[23] = mk(0, 1, 2, 2, 1, 1, 1, 0, 4, 0,  0, 0, 0, 1,  0, 0, 1, 1); // stall
    tbl[24] = mk(0, 1, 2, 2, 1, 1, 1, 0, 4, 1,  1, 1, 1, 1,  0, 0, 2, 1); // branch squashes it
    tbl[25] = mk(0, 1, 4, 4, 1, 1, 1, 0, 9, 0,  1, 1, 0, 0,  0, 0, 2, 2); // reader of $4
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 2, 2); // squashed: no fwd

    // ---- reset held for two cycles ---------------------------------------
    r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0);
    reset = 1'b1;
    bus.ID_Valid = 0; bus.ID_Rs = 0; bus.ID_Rt = 0; bus.ID_UsesRs = 0; bus.ID_UsesRt = 0;
    bus.ID_RegWrite = 0; bus.ID_MemRead = 0; bus.ID_WriteReg = 0; bus.EX_BranchTaken = 0;
    repeat (2) @(posedge clk);
    #1;
    apply_row(r, "reset");

    for (int i = 0; i < 27; i++) apply_row(tbl[i], $sformatf("tbl%0d", i));

    // ---- reset asserted during a load-use stall --------------------------
    apply_row(mk(0, 1, 1, 2, 1, 0, 1, 1, 2, 0,  1, 1, 0, 0,  0, 0, 2, 2), "rst_stall.lw");
    apply_row(mk(1, 1, 2, 2, 1, 1, 1, 0, 4, 0,  1, 1, 0, 0,  0, 0, 2, 2), "rst_stall.hit");
    apply_row(mk(0, 1, 2, 2, 1, 1, 1, 0, 4, 0,  1, 1, 0, 0,  0, 0, 0, 0), "rst_stall.after");
    apply_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0,  0, 0, 0, 0), "rst_stall.empty");

    // ---- randomized traffic against the model ----------------------------
    for (int k = 0; k < 3; k++) hist[k] = '0;
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
    held = 0;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      r.rst = (n == 0) || ($urandom_range(0, 99) == 0);
      if (!held) begin
        r.v  = ($urandom_range(0, 9) < 8);
        r.rs = 5'($urandom_range(0, 7));
        r.rt = 5'($urandom_range(0, 7));
        r.us = r.v && $urandom_range(0, 3) != 0;
        r.ut = r.v && $urandom_range(0, 1) != 0;
        r.wr = $urandom_range(0, 3) != 0;
        r.ld = r.wr && ($urandom_range(0, 9) < 3);
        r.wd = 5'($urandom_range(0, 7));
      end
      r.br = ($urandom_range(0, 9) == 0);

      lu = r.v && hist[0].v && hist[0].ld &&
           ((r.us && writes(hist[0], r.rs)) || (r.ut && writes(hist[0], r.rt)));
      r.pc  = r.rst || r.br || !lu;
      r.ifw = r.rst || r.br || !lu;
      r.fl  = !r.rst && r.br;
      r.bub = !r.rst && (r.br || lu);
      r.fa  = m_fa;
      r.fb  = m_fb;
      r.sc  = m_sc;
      r.fc  = m_fc;
      apply_row(r, $sformatf("rnd%0d", n));

      if (r.rst) begin
        for (int k = 0; k < 3; k++) hist[k] = '0;
        m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
        held = 0;
      end else begin
        m_fa = (r.br || lu) ? 2'b00 : fwd_for(r.us, r.rs);
        m_fb = (r.br || lu) ? 2'b00 : fwd_for(r.ut, r.rt);
        if (r.br && m_fc != 32'hFFFF_FFFF) m_fc++;
        else if (lu && m_sc != 32'hFFFF_FFFF) m_sc++;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = (r.br || lu) ? ent_t'(0) : ent_t'{r.v, r.wr, r.ld, r.wd};
        held = lu && !r.br;   // a stalled ID instruction is presented again
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
